// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared fetch-stage definitions
//   state_t         byte-assembler FSM states (B0..B3 = byte index, HOLD = word waiting for space)
//   BYTES_PER_WORD  fetch PC increment per assembled word
//   NOP_WORD        value presented on inst_data when the queue is empty
package inst_fetch_queue_pkg;

    typedef enum logic [2:0] {
        B0   = 3'd0,
        B1   = 3'd1,
        B2   = 3'd2,
        B3   = 3'd3,
        HOLD = 3'd4
    } state_t;

    localparam logic [31:0] BYTES_PER_WORD = 32'd4;
    localparam logic [31:0] NOP_WORD       = 32'h0;

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// inst_fetch_queue_fifo: DEPTH x W synchronous FIFO with push/pop/flush and occupancy count
//   clk, rst_n  clock, asynchronous active-low reset
//   push, din   write din at the tail
//   pop         retire the head
//   flush       clear the queue; overrides push and pop
//   dout        raw head entry (meaningless when count == 0)
//   count       occupied entries
module inst_fetch_queue_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= din;
    end

    // Pointers are exactly PW bits wide, so they wrap at DEPTH with no compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: byte-serial instruction fetch, big-endian word assembly and instruction queue
//   clk, rst_n                   clock, asynchronous active-low reset
//   imem_addr, imem_rd           byte address and read strobe to the instruction ROM
//   imem_data                    ROM byte, valid in the same cycle
//   inst_valid, inst_ready       head handshake toward the core
//   inst_data, inst_pc           head word and its PC, 0 when empty
//   redirect_valid, redirect_pc  flush the queue and restart fetch at redirect_pc & ~3
//   q_count                      queue occupancy
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [ADDR_W-1:0]      imem_addr,
    output logic                   imem_rd,
    input  logic [7:0]             imem_data,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [31:0]            inst_data,
    output logic [31:0]            inst_pc,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t      state, state_d;
    logic [31:0] fetch_pc, pc_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] word;
    logic [63:0] head;
    logic [1:0]  byte_idx;
    logic        push, pop, space;

    assign inst_valid = q_count != '0;
    assign pop        = inst_valid & inst_ready;
    // A pop on the same edge frees the slot the push needs, even when full.
    assign space      = (q_count != CW'(DEPTH)) | pop;
    // HOLD keeps the address of the last byte read rather than returning to byte 0.
    assign byte_idx   = (state == HOLD) ? 2'd3 : state[1:0];
    assign imem_addr  = fetch_pc[ADDR_W-1:0] + ADDR_W'(byte_idx);
    assign imem_rd    = state != HOLD;
    // In B3 the last byte comes straight from the ROM; in HOLD it was latched earlier.
    assign word       = (state == HOLD) ? asm_q : {asm_q[31:8], imem_data};
    assign inst_data  = inst_valid ? head[63:32] : NOP_WORD;
    assign inst_pc    = inst_valid ? head[31:0] : 32'h0;

    always_comb begin
        state_d = state;
        pc_d    = fetch_pc;
        asm_d   = asm_q;
        push    = 1'b0;
        if (redirect_valid) begin
            state_d = B0;
            pc_d    = redirect_pc & ~32'd3;
        end else begin
            case (state)
                B0: begin
                    asm_d[31:24] = imem_data;
                    state_d      = B1;
                end
                B1: begin
                    asm_d[23:16] = imem_data;
                    state_d      = B2;
                end
                B2: begin
                    asm_d[15:8] = imem_data;
                    state_d     = B3;
                end
                B3: begin
                    if (space) begin
                        push    = 1'b1;
                        pc_d    = fetch_pc + BYTES_PER_WORD;
                        state_d = B0;
                    end else begin
                        asm_d[7:0] = imem_data;
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (space) begin
                        push    = 1'b1;
                        pc_d    = fetch_pc + BYTES_PER_WORD;
                        state_d = B0;
                    end
                end
                default: state_d = B0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= B0;
            fetch_pc <= RESET_PC;
            asm_q    <= '0;
        end else begin
            state    <= state_d;
            fetch_pc <= pc_d;
            asm_q    <= asm_d;
        end
    end

    inst_fetch_queue_fifo #(
        .DEPTH (DEPTH),
        .W     (64)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({word, fetch_pc}),
        .dout  (head),
        .count (q_count)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic [4:0]  imem_addr;
    logic        imem_rd;
    logic [7:0]  imem_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  q_count;

    logic [7:0]  rom [32];
    int          errors = 0;
    int          checks = 0;

    inst_fetch_queue #(
        .DEPTH    (4),
        .ADDR_W   (5),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .imem_data      (imem_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .q_count        (q_count)
    );

    assign imem_data = rom[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the negedge inside cycle 0.
    task automatic do_reset();
        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_count", 64'(q_count), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_rd", 64'(imem_rd), 64'd1);
        check("rst_data", 64'(inst_data), 64'd0);
        check("rst_pc", 64'(inst_pc), 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        rom[0] = 8'h8C; rom[1] = 8'h22; rom[2] = 8'h00; rom[3] = 8'h04;
        rom[4] = 8'h00; rom[5] = 8'h22; rom[6] = 8'h18; rom[7] = 8'h20;
        for (int i = 8; i < 32; i++) rom[i] = 8'(i);

        // basic streaming with the core always ready
        do_reset();
        inst_ready = 1'b1;
        check("t1_c0_addr", 64'(imem_addr), 64'h00);
        cyc(1);
        check("t1_c1_addr", 64'(imem_addr), 64'h01);
        check("t1_c1_valid", 64'(inst_valid), 64'd0);
        cyc(3);
        check("t1_c4_valid", 64'(inst_valid), 64'd1);
        check("t1_c4_data", 64'(inst_data), 64'h8C220004);
        check("t1_c4_pc", 64'(inst_pc), 64'h0);
        check("t1_c4_count", 64'(q_count), 64'd1);
        cyc(1);
        check("t1_c5_valid", 64'(inst_valid), 64'd0);
        cyc(3);
        check("t1_c8_data", 64'(inst_data), 64'h00221820);
        check("t1_c8_pc", 64'(inst_pc), 64'h4);

        // fill to full, HOLD, then simultaneous push/pop when full
        do_reset();
        cyc(16);
        check("t2_c16_count", 64'(q_count), 64'd4);
        check("t2_c16_addr", 64'(imem_addr), 64'h10);
        cyc(4);
        check("t2_hold_rd", 64'(imem_rd), 64'd0);
        check("t2_hold_addr", 64'(imem_addr), 64'h13);
        check("t2_hold_count", 64'(q_count), 64'd4);
        check("t2_hold_pc", 64'(inst_pc), 64'h0);
        inst_ready = 1'b1;
        cyc(1);
        inst_ready = 1'b0;
        check("t2_pp_count", 64'(q_count), 64'd4);
        check("t2_pp_pc", 64'(inst_pc), 64'h4);
        check("t2_pp_addr", 64'(imem_addr), 64'h14);
        check("t2_pp_rd", 64'(imem_rd), 64'd1);
        inst_ready = 1'b1;
        cyc(3);
        check("t2_c24_pc", 64'(inst_pc), 64'h10);
        check("t2_c24_data", 64'(inst_data), 64'h10111213);
        check("t2_c24_count", 64'(q_count), 64'd1);
        cyc(1);
        check("t2_c25_pc", 64'(inst_pc), 64'h14);
        check("t2_c25_data", 64'(inst_data), 64'h14151617);
        check("t2_c25_count", 64'(q_count), 64'd1);

        // redirect during B2 with two words queued, unaligned target
        do_reset();
        cyc(10);
        check("t3_pre_count", 64'(q_count), 64'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000000A;
        cyc(1);
        redirect_valid = 1'b0;
        check("t3_count", 64'(q_count), 64'd0);
        check("t3_valid", 64'(inst_valid), 64'd0);
        check("t3_addr", 64'(imem_addr), 64'h08);
        check("t3_data", 64'(inst_data), 64'h0);
        inst_ready = 1'b1;
        cyc(4);
        check("t3_new_valid", 64'(inst_valid), 64'd1);
        check("t3_new_pc", 64'(inst_pc), 64'h08);
        check("t3_new_data", 64'(inst_data), 64'h08090A0B);

        // redirect coinciding with a push (B3) and a pop
        do_reset();
        cyc(11);
        check("t4_pre_count", 64'(q_count), 64'd2);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00000010;
        cyc(1);
        redirect_valid = 1'b0;
        check("t4_count", 64'(q_count), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("t4_no_old", 64'(inst_valid), 64'd0);
            cyc(1);
        end
        check("t4_new_pc", 64'(inst_pc), 64'h10);
        check("t4_new_data", 64'(inst_data), 64'h10111213);

        // memory address wrap while the 32-bit PC keeps counting
        do_reset();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000001C;
        cyc(1);
        redirect_valid = 1'b0;
        check("t5_addr_1c", 64'(imem_addr), 64'h1C);
        cyc(4);
        check("t5_pc_1c", 64'(inst_pc), 64'h1C);
        check("t5_data_1c", 64'(inst_data), 64'h1C1D1E1F);
        check("t5_wrap_addr", 64'(imem_addr), 64'h00);
        cyc(4);
        check("t5_pc_20", 64'(inst_pc), 64'h20);
        check("t5_data_20", 64'(inst_data), 64'h8C220004);

        // asynchronous reset mid-B1 with three words queued
        do_reset();
        cyc(13);
        check("t6_pre_count", 64'(q_count), 64'd3);
        rst_n = 1'b0;
        #1;
        check("t6_valid", 64'(inst_valid), 64'd0);
        check("t6_count", 64'(q_count), 64'd0);
        check("t6_addr", 64'(imem_addr), 64'h00);
        check("t6_rd", 64'(imem_rd), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4);
        check("t6_after_valid", 64'(inst_valid), 64'd1);
        check("t6_after_pc", 64'(inst_pc), 64'h0);
        check("t6_after_data", 64'(inst_data), 64'h8C220004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
